// File: rtl/ascon_pack.sv
// rtl/ascon_pack.sv - shared ASCON state type, inverse S-box table and FSM enum
package ascon_pack;

    // Row r of the state is s[r]; s[r][i] is bit i of that 64-bit row.
    typedef logic [4:0][63:0] type_state;

    localparam logic [0:31][4:0] INV_SBOX_TABLE = {
        5'h14, 5'h1A, 5'h07, 5'h0D, 5'h00, 5'h09, 5'h0E, 5'h12,
        5'h0A, 5'h06, 5'h1D, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1E,
        5'h18, 5'h16, 5'h0B, 5'h11, 5'h03, 5'h05, 5'h1C, 5'h1F,
        5'h17, 5'h1B, 5'h04, 5'h08, 5'h0F, 5'h0C, 5'h10, 5'h02
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } type_inv_sub_fsm;

endpackage

// File: rtl/inv_sbox.sv
// rtl/inv_sbox.sv - combinational 5-bit ASCON inverse S-box lookup
module inv_sbox
    import ascon_pack::*;
(
    input  logic [4:0] inv_sbox_i,
    output logic [4:0] inv_sbox_o
);

    assign inv_sbox_o = INV_SBOX_TABLE[inv_sbox_i];

endmodule

// File: rtl/inv_substitution_layer_seq.sv
// rtl/inv_substitution_layer_seq.sv - iterative inverse ASCON substitution layer
module inv_substitution_layer_seq
    import ascon_pack::*;
#(
    parameter int SBOX_PER_CYCLE = 8
) (
    input  logic      clock_i,
    input  logic      reset_i,
    input  logic      start_i,
    input  type_state state_i,
    output type_state state_o,
    output logic      busy_o,
    output logic      done_o
);

    localparam int NB_STEPS = 64 / SBOX_PER_CYCLE;
    localparam int CNT_W    = (NB_STEPS > 1) ? $clog2(NB_STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NB_STEPS - 1);

    if (SBOX_PER_CYCLE < 1 || SBOX_PER_CYCLE > 64 || (64 % SBOX_PER_CYCLE) != 0) begin : g_bad_param
        $error("SBOX_PER_CYCLE must be one of 1, 2, 4, 8, 16, 32, 64");
    end

    type_inv_sub_fsm fsm_q, fsm_d;
    logic [CNT_W-1:0] cnt;
    type_state        work;
    logic             capture;

    logic [5:0] col_idx [SBOX_PER_CYCLE];
    logic [4:0] sb_in   [SBOX_PER_CYCLE];
    logic [4:0] sb_out  [SBOX_PER_CYCLE];

    // A start while RUN is in flight is deliberately dropped.
    assign capture = start_i && (fsm_q != RUN);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (start_i) fsm_d = RUN;
            RUN:     if (cnt == LAST_STEP) fsm_d = DONE;
            DONE:    if (start_i) fsm_d = RUN;
            default: fsm_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (fsm_q == RUN);
        done_o = (fsm_q == DONE);
    end

    for (genvar j = 0; j < SBOX_PER_CYCLE; j++) begin : g_sbox
        assign col_idx[j] = 6'(int'(cnt) * SBOX_PER_CYCLE + j);
        assign sb_in[j]   = {work[0][col_idx[j]], work[1][col_idx[j]], work[2][col_idx[j]],
                             work[3][col_idx[j]], work[4][col_idx[j]]};

        inv_sbox u_inv_sbox (
            .inv_sbox_i (sb_in[j]),
            .inv_sbox_o (sb_out[j])
        );
    end

    // Columns are rewritten in place; the counter parks on the last step.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cnt  <= '0;
            work <= '0;
        end else if (capture) begin
            cnt  <= '0;
            work <= state_i;
        end else if (fsm_q == RUN) begin
            for (int j = 0; j < SBOX_PER_CYCLE; j++) begin
                for (int r = 0; r < 5; r++) begin
                    work[r][col_idx[j]] <= sb_out[j][4-r];
                end
            end
            if (cnt != LAST_STEP) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign state_o = work;

endmodule

// File: tb/tb_inv_substitution_layer_seq.sv
// tb/tb_inv_substitution_layer_seq.sv - scoreboard bench for P=1, 8 and 64 instances
module tb_inv_substitution_layer_seq;
    import ascon_pack::*;

    localparam logic [0:31][4:0] INV_T = {
        5'h14, 5'h1A, 5'h07, 5'h0D, 5'h00, 5'h09, 5'h0E, 5'h12,
        5'h0A, 5'h06, 5'h1D, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1E,
        5'h18, 5'h16, 5'h0B, 5'h11, 5'h03, 5'h05, 5'h1C, 5'h1F,
        5'h17, 5'h1B, 5'h04, 5'h08, 5'h0F, 5'h0C, 5'h10, 5'h02
    };
    localparam logic [0:31][4:0] FWD_T = {
        5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
        5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
        5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
        5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
    };
    localparam int LAT [3] = '{64, 8, 1};

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    logic      start_v [3];
    type_state sin_v   [3];
    type_state sout_v  [3];
    logic      busy_v  [3];
    logic      done_v  [3];

    type_state q_p1 [$];
    type_state q_p8 [$];
    type_state q_p64 [$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    inv_substitution_layer_seq #(.SBOX_PER_CYCLE(1)) u_p1 (
        .clock_i(clk), .reset_i(rst), .start_i(start_v[0]), .state_i(sin_v[0]),
        .state_o(sout_v[0]), .busy_o(busy_v[0]), .done_o(done_v[0]));
    inv_substitution_layer_seq #(.SBOX_PER_CYCLE(8)) u_p8 (
        .clock_i(clk), .reset_i(rst), .start_i(start_v[1]), .state_i(sin_v[1]),
        .state_o(sout_v[1]), .busy_o(busy_v[1]), .done_o(done_v[1]));
    inv_substitution_layer_seq #(.SBOX_PER_CYCLE(64)) u_p64 (
        .clock_i(clk), .reset_i(rst), .start_i(start_v[2]), .state_i(sin_v[2]),
        .state_o(sout_v[2]), .busy_o(busy_v[2]), .done_o(done_v[2]));

    function automatic logic [4:0] col_of(input type_state s, input int i);
        return {s[0][i], s[1][i], s[2][i], s[3][i], s[4][i]};
    endfunction

    function automatic type_state apply_tab(input type_state s, input bit inv);
        type_state r;
        logic [4:0] v, o;
        for (int i = 0; i < 64; i++) begin
            v = col_of(s, i);
            o = inv ? INV_T[v] : FWD_T[v];
            for (int b = 0; b < 5; b++) r[b][i] = o[4-b];
        end
        return r;
    endfunction

    function automatic type_state rand_state();
        type_state s;
        for (int r = 0; r < 5; r++) s[r] = {$urandom, $urandom};
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch8(input type_state s, input type_state e);
        sin_v[1] = s;
        q_p8.push_back(e);
        start_v[1] = 1'b1;
        tick();
        start_v[1] = 1'b0;
    endtask

    task automatic wait_done8(output int lat);
        lat = -1;
        for (int k = 1; k <= 80; k++) begin
            tick();
            if (done_v[1]) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 || sout_v[i] !== '0) begin
                bad++;
                $display("FAIL reset_state[%0d]: got busy=%b done=%b state=%h want 0 0 0",
                         i, busy_v[i], done_v[i], sout_v[i]);
            end
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_zeros();
        type_state e, got;
        int lat;
        e = '0;
        e[0] = '1;
        e[2] = '1;
        launch8('0, e);
        total++;
        if (busy_v[1] !== 1'b1 || done_v[1] !== 1'b0) begin
            bad++;
            $display("FAIL zeros_busy: got busy=%b done=%b want 1 0", busy_v[1], done_v[1]);
        end
        wait_done8(lat);
        total++;
        if (lat !== 8) begin
            bad++;
            $display("FAIL zeros_latency: got %0d want 8", lat);
        end
        got = q_p8.pop_front();
        total++;
        if (sout_v[1] !== got) begin
            bad++;
            $display("FAIL zeros_result: got %h want %h", sout_v[1], got);
        end
    endtask

    task automatic test_exhaustive();
        type_state s, e, got;
        int lat;
        logic [4:0] c1, c31;
        for (int k = 0; k < 64; k++) begin
            for (int b = 0; b < 5; b++) begin
                s[b][k] = 1'((k % 32) >> (4 - b));
                e[b][k] = INV_T[k % 32][4-b];
            end
        end
        launch8(s, e);
        wait_done8(lat);
        total++;
        if (lat !== 8) begin
            bad++;
            $display("FAIL exhaustive_latency: got %0d want 8", lat);
        end
        got = q_p8.pop_front();
        total++;
        if (sout_v[1] !== got) begin
            bad++;
            $display("FAIL exhaustive_result: got %h want %h", sout_v[1], got);
        end
        c1  = col_of(sout_v[1], 1);
        c31 = col_of(sout_v[1], 31);
        total++;
        if (c1 !== 5'h1A || c31 !== 5'h02) begin
            bad++;
            $display("FAIL exhaustive_cols: got col1=%h col31=%h want 1a 02", c1, c31);
        end
    endtask

    task automatic test_back_to_back();
        type_state s, got;
        int lat;
        s = rand_state();
        launch8(s, apply_tab(s, 1'b1));
        lat = -1;
        for (int k = 1; k <= 80; k++) begin
            tick();
            start_v[1] = 1'b0;
            if (done_v[1]) begin
                lat = k;
                break;
            end
            if (k == 2 || k == 4) begin
                start_v[1] = 1'b1;
                sin_v[1]   = rand_state();
            end
        end
        total++;
        if (lat !== 8) begin
            bad++;
            $display("FAIL ignore_start_latency: got %0d want 8", lat);
        end
        got = q_p8.pop_front();
        total++;
        if (sout_v[1] !== got) begin
            bad++;
            $display("FAIL ignore_start_result: got %h want %h", sout_v[1], got);
        end
        s = rand_state();
        launch8(s, apply_tab(s, 1'b1));
        total++;
        if (done_v[1] !== 1'b0 || busy_v[1] !== 1'b1) begin
            bad++;
            $display("FAIL relaunch_flags: got done=%b busy=%b want 0 1", done_v[1], busy_v[1]);
        end
        wait_done8(lat);
        total++;
        if (lat !== 8) begin
            bad++;
            $display("FAIL relaunch_latency: got %0d want 8", lat);
        end
        got = q_p8.pop_front();
        total++;
        if (sout_v[1] !== got) begin
            bad++;
            $display("FAIL relaunch_result: got %h want %h", sout_v[1], got);
        end
    endtask

    task automatic test_reset_mid_run();
        type_state s, got;
        int lat;
        sin_v[1]   = rand_state();
        start_v[1] = 1'b1;
        tick();
        start_v[1] = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (busy_v[1] !== 1'b0 || done_v[1] !== 1'b0 || sout_v[1] !== '0) begin
            bad++;
            $display("FAIL midrun_reset: got busy=%b done=%b state=%h want 0 0 0",
                     busy_v[1], done_v[1], sout_v[1]);
        end
        s = rand_state();
        launch8(s, apply_tab(s, 1'b1));
        wait_done8(lat);
        total++;
        if (lat !== 8) begin
            bad++;
            $display("FAIL post_reset_latency: got %0d want 8", lat);
        end
        got = q_p8.pop_front();
        total++;
        if (sout_v[1] !== got) begin
            bad++;
            $display("FAIL post_reset_result: got %h want %h", sout_v[1], got);
        end
    endtask

    task automatic test_reset_start();
        rst        = 1'b1;
        start_v[1] = 1'b1;
        sin_v[1]   = rand_state();
        tick();
        rst        = 1'b0;
        start_v[1] = 1'b0;
        total++;
        if (busy_v[1] !== 1'b0 || done_v[1] !== 1'b0 || sout_v[1] !== '0) begin
            bad++;
            $display("FAIL reset_vs_start: got busy=%b done=%b state=%h want 0 0 0",
                     busy_v[1], done_v[1], sout_v[1]);
        end
        tick();
        total++;
        if (busy_v[1] !== 1'b0 || done_v[1] !== 1'b0) begin
            bad++;
            $display("FAIL reset_vs_start_idle: got busy=%b done=%b want 0 0", busy_v[1], done_v[1]);
        end
    endtask

    task automatic test_roundtrip();
        type_state orig, fwd, got;
        int lat [3];
        for (int n = 0; n < 1000; n++) begin
            orig = rand_state();
            fwd  = apply_tab(orig, 1'b0);
            q_p1.push_back(orig);
            q_p8.push_back(orig);
            q_p64.push_back(orig);
            for (int i = 0; i < 3; i++) begin
                sin_v[i]   = fwd;
                start_v[i] = 1'b1;
                lat[i]     = -1;
            end
            tick();
            for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
            for (int k = 1; k <= 70; k++) begin
                tick();
                for (int i = 0; i < 3; i++) begin
                    if (lat[i] < 0 && done_v[i]) begin
                        lat[i] = k;
                        got = (i == 0) ? q_p1.pop_front() : (i == 1) ? q_p8.pop_front() : q_p64.pop_front();
                        total++;
                        if (sout_v[i] !== got) begin
                            bad++;
                            $display("FAIL roundtrip_result[%0d] n=%0d: got %h want %h", i, n, sout_v[i], got);
                        end
                    end
                end
                if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
            end
            for (int i = 0; i < 3; i++) begin
                total++;
                if (lat[i] !== LAT[i]) begin
                    bad++;
                    $display("FAIL roundtrip_latency[%0d] n=%0d: got %0d want %0d", i, n, lat[i], LAT[i]);
                    if (lat[i] < 0) begin
                        if (i == 0) void'(q_p1.pop_front());
                        else if (i == 1) void'(q_p8.pop_front());
                        else void'(q_p64.pop_front());
                    end
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            sin_v[i]   = '0;
        end
        test_reset();
        test_zeros();
        test_exhaustive();
        test_back_to_back();
        test_reset_mid_run();
        test_reset_start();
        test_roundtrip();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
